// File: rtl/orbit_phase_tracker.sv
// Live angular position counters for Mercury, Venus and Earth, with per-frame
// snapshot outputs, orbit-completion pulses and a saturating Earth-year counter.
module orbit_phase_tracker #(
  parameter int ANGLE_STEPS = 360,
  parameter int ANGLE_W     = 9
) (
  input  logic               clk1485,
  input  logic               rst,
  input  logic               tick_mercur,
  input  logic               tick_venus,
  input  logic               tick_earth,
  input  logic               run,
  input  logic               reverse,
  input  logic               frame_start,
  output logic [ANGLE_W-1:0] angle_mercur,
  output logic [ANGLE_W-1:0] angle_venus,
  output logic [ANGLE_W-1:0] angle_earth,
  output logic               angle_valid,
  output logic               orbit_mercur,
  output logic               orbit_venus,
  output logic               orbit_earth,
  output logic [7:0]         earth_years
);

  typedef logic [ANGLE_W-1:0] angle_t;

  localparam angle_t MAX_ANGLE = angle_t'(ANGLE_STEPS - 1);
  localparam int     EARTH     = 2;

  angle_t     live_q  [3];
  angle_t     live_d  [3];
  angle_t     snap_q  [3];
  angle_t     snap_d  [3];
  logic [2:0] orbit_q;
  logic [2:0] orbit_d;
  logic       valid_q;
  logic [7:0] years_q;
  logic [7:0] years_d;
  logic [2:0] advance;

  assign advance = {tick_earth, tick_venus, tick_mercur} & {3{run}};

  // Wrap is detected before stepping so no counter value ever reaches ANGLE_STEPS.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      live_d[p]  = live_q[p];
      orbit_d[p] = 1'b0;
      snap_d[p]  = frame_start ? live_q[p] : snap_q[p];
      if (advance[p]) begin
        if (!reverse) begin
          if (live_q[p] == MAX_ANGLE) begin
            live_d[p]  = '0;
            orbit_d[p] = 1'b1;
          end else begin
            live_d[p] = live_q[p] + angle_t'(1);
          end
        end else begin
          if (live_q[p] == '0) begin
            live_d[p]  = MAX_ANGLE;
            orbit_d[p] = 1'b1;
          end else begin
            live_d[p] = live_q[p] - angle_t'(1);
          end
        end
      end
    end

    years_d = years_q;
    if (orbit_d[EARTH]) begin
      if (!reverse && years_q != 8'hFF) begin
        years_d = years_q + 8'd1;
      end else if (reverse && years_q != 8'h00) begin
        years_d = years_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk1485) begin
    if (rst) begin
      for (int p = 0; p < 3; p++) begin
        live_q[p] <= '0;
        snap_q[p] <= '0;
      end
      orbit_q <= '0;
      valid_q <= 1'b0;
      years_q <= '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        live_q[p] <= live_d[p];
        snap_q[p] <= snap_d[p];
      end
      orbit_q <= orbit_d;
      valid_q <= frame_start;
      years_q <= years_d;
    end
  end

  assign angle_mercur = snap_q[0];
  assign angle_venus  = snap_q[1];
  assign angle_earth  = snap_q[2];
  assign angle_valid  = valid_q;
  assign orbit_mercur = orbit_q[0];
  assign orbit_venus  = orbit_q[1];
  assign orbit_earth  = orbit_q[2];
  assign earth_years  = years_q;

endmodule

// File: tb/tb_orbit_phase_tracker.sv
// Directed self-checking bench for orbit_phase_tracker with hand-computed
// angle, orbit-pulse and year expectations.
`timescale 1ns/1ps
module tb_orbit_phase_tracker;

  localparam int ANGLE_W = 9;

  logic               clk1485;
  logic               rst;
  logic               tick_mercur;
  logic               tick_venus;
  logic               tick_earth;
  logic               run;
  logic               reverse;
  logic               frame_start;
  logic [ANGLE_W-1:0] angle_mercur;
  logic [ANGLE_W-1:0] angle_venus;
  logic [ANGLE_W-1:0] angle_earth;
  logic               angle_valid;
  logic               orbit_mercur;
  logic               orbit_venus;
  logic               orbit_earth;
  logic [7:0]         earth_years;

  int checkCount  = 0;
  int errorCount  = 0;
  int orbitPulses = 0;

  orbit_phase_tracker #(.ANGLE_STEPS(360), .ANGLE_W(ANGLE_W)) dut (
    .clk1485     (clk1485),
    .rst         (rst),
    .tick_mercur (tick_mercur),
    .tick_venus  (tick_venus),
    .tick_earth  (tick_earth),
    .run         (run),
    .reverse     (reverse),
    .frame_start (frame_start),
    .angle_mercur(angle_mercur),
    .angle_venus (angle_venus),
    .angle_earth (angle_earth),
    .angle_valid (angle_valid),
    .orbit_mercur(orbit_mercur),
    .orbit_venus (orbit_venus),
    .orbit_earth (orbit_earth),
    .earth_years (earth_years)
  );

  initial clk1485 = 1'b0;
  always #5 clk1485 = ~clk1485;

  // Holds the given pulses for one rising edge, then returns 1 ns after it.
  task automatic applyStimulus(input logic [2:0] ticks, input logic fs, input logic r);
    tick_mercur = ticks[0];
    tick_venus  = ticks[1];
    tick_earth  = ticks[2];
    frame_start = fs;
    rst         = r;
    @(posedge clk1485);
    #1;
    tick_mercur = 1'b0;
    tick_venus  = 1'b0;
    tick_earth  = 1'b0;
    frame_start = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic repeatTicks(input logic [2:0] ticks, input int n);
    for (int i = 0; i < n; i++) applyStimulus(ticks, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAngles(input string tag, input int m, input int v, input int e);
    checkOutput({tag, "_mercur"}, 32'(angle_mercur), 32'(m));
    checkOutput({tag, "_venus"},  32'(angle_venus),  32'(v));
    checkOutput({tag, "_earth"},  32'(angle_earth),  32'(e));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; reverse = 1'b0; frame_start = 1'b0;
    tick_mercur = 1'b0; tick_venus = 1'b0; tick_earth = 1'b0;

    // Reset, with pulses present that must be discarded
    applyStimulus(3'b111, 1'b1, 1'b1);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkAngles("reset", 0, 0, 0);
    checkOutput("reset_valid", 32'(angle_valid), 0);
    checkOutput("reset_orbits", 32'({orbit_earth, orbit_venus, orbit_mercur}), 0);
    checkOutput("reset_years", 32'(earth_years), 0);

    // Forward: five back-to-back Mercury ticks then a snapshot
    run = 1'b1;
    repeatTicks(3'b001, 5);
    checkOutput("prefs_valid", 32'(angle_valid), 0);
    checkAngles("prefs", 0, 0, 0);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("fwd_valid", 32'(angle_valid), 1);
    checkAngles("fwd", 5, 0, 0);
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("fwd_valid_drop", 32'(angle_valid), 0);
    checkOutput("fwd_hold", 32'(angle_mercur), 5);

    // Forward wrap: 360 Earth ticks give exactly one orbit pulse on the last one
    orbitPulses = 0;
    for (int i = 0; i < 360; i++) begin
      applyStimulus(3'b100, 1'b0, 1'b0);
      if (orbit_earth) orbitPulses++;
    end
    checkOutput("wrap_pulse_last", 32'(orbit_earth), 1);
    checkOutput("wrap_pulse_count", 32'(orbitPulses), 1);
    checkOutput("wrap_years", 32'(earth_years), 1);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("wrap_pulse_drop", 32'(orbit_earth), 0);
    checkAngles("wrap", 5, 0, 0);

    // Pause: ticks on every planet are ignored while run is low
    run = 1'b0;
    repeatTicks(3'b111, 10);
    checkOutput("pause_orbits", 32'({orbit_earth, orbit_venus, orbit_mercur}), 0);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkAngles("pause", 5, 0, 0);
    run = 1'b1;
    applyStimulus(3'b001, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkAngles("resume", 6, 0, 0);

    // Snapshot and tick in the same cycle capture the pre-tick value
    repeatTicks(3'b010, 41);
    applyStimulus(3'b010, 1'b1, 1'b0);
    checkOutput("simul_venus", 32'(angle_venus), 41);
    checkOutput("simul_valid", 32'(angle_valid), 1);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("simul_next", 32'(angle_venus), 42);

    // Reverse wrap from reset: year count holds at zero
    applyStimulus(3'b000, 1'b0, 1'b1);
    reverse = 1'b1;
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("rev_pulse", 32'(orbit_earth), 1);
    checkOutput("rev_years_sat", 32'(earth_years), 0);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkAngles("rev", 0, 0, 359);
    reverse = 1'b0;
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("refwd_pulse", 32'(orbit_earth), 1);
    checkOutput("refwd_years", 32'(earth_years), 1);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("refwd_angle", 32'(angle_earth), 0);
    reverse = 1'b1;
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("rev_years_dec", 32'(earth_years), 0);
    reverse = 1'b0;
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("refwd2_years", 32'(earth_years), 1);

    // Build up state, then reset together with a tick and a snapshot
    repeatTicks(3'b100, 720);
    checkOutput("three_years", 32'(earth_years), 3);
    repeatTicks(3'b011, 3);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkAngles("premid", 3, 3, 0);
    applyStimulus(3'b111, 1'b1, 1'b1);
    checkAngles("midrst", 0, 0, 0);
    checkOutput("midrst_valid", 32'(angle_valid), 0);
    checkOutput("midrst_orbits", 32'({orbit_earth, orbit_venus, orbit_mercur}), 0);
    checkOutput("midrst_years", 32'(earth_years), 0);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkAngles("postrst", 0, 0, 0);
    checkOutput("postrst_valid", 32'(angle_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/orbit_phase_tracker.md
# orbit_phase_tracker

Consumes the per-planet orbit tick pulses on the 148.5 MHz domain and keeps a live angular position counter for Mercury, Venus and Earth. On each frame-start pulse it snapshots all three angles into stable output registers, so the sprite/trig lookup stage reads consistent positions for the whole frame. It also flags completed orbits and keeps an Earth-year counter for the on-screen overlay.

## Interface
Parameters:
- `ANGLE_STEPS`, default 360: positions per orbit; legal range 2..2^ANGLE_W.
- `ANGLE_W`, default 9: width of the angle counters.

Ports:
- `clk1485`  in  1  148.5 MHz system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick_mercur`  in  1  single-cycle advance pulse for Mercury.
- `tick_venus`  in  1  single-cycle advance pulse for Venus.
- `tick_earth`  in  1  single-cycle advance pulse for Earth.
- `run`  in  1  1 = ticks advance angles; 0 = ticks ignored (pause).
- `reverse`  in  1  0 = ticks increment angles; 1 = ticks decrement angles.
- `frame_start`  in  1  single-cycle pulse at start of vertical blank; triggers the snapshot.
- `angle_mercur`  out  ANGLE_W  snapshot of Mercury angle.
- `angle_venus`  out  ANGLE_W  snapshot of Venus angle.
- `angle_earth`  out  ANGLE_W  snapshot of Earth angle.
- `angle_valid`  out  1  one-cycle pulse: snapshot outputs just updated.
- `orbit_mercur`, `orbit_venus`, `orbit_earth`  out  1 each  one-cycle pulse on angle wrap.
- `earth_years`  out  8  signed-direction year count, saturating 0..255.

## Operation
- Three independent live counters `live_*`, each ANGLE_W bits, range 0..ANGLE_STEPS-1. None is visible at the ports.
- Advance condition per planet: `tick_x & run` sampled in the same cycle.
  - Forward (reverse=0): live+1. At ANGLE_STEPS-1 it wraps to 0 and pulses `orbit_x`.
  - Reverse (reverse=1): live-1. At 0 it wraps to ANGLE_STEPS-1 and pulses `orbit_x`.
- Counters never take values ≥ ANGLE_STEPS. No intermediate value can overflow ANGLE_W bits: compare against ANGLE_STEPS-1 before incrementing.
- `earth_years`:
  - Increments on a forward Earth wrap and decrements on a reverse Earth wrap.
  - Saturates at 255 and 0: the `orbit_earth` pulse still fires at saturation, but the count does not change.
- Snapshot:
  - When `frame_start`=1, all three live values from that cycle load into `angle_*` together.
  - Outputs hold until the next `frame_start`, independent of `run` and ticks.
- Simultaneous tick and `frame_start` in the same cycle: the snapshot captures the pre-increment value, and the live counter updates normally. The new value appears in the next frame.
- Simultaneous ticks on several planets: each updates independently in the same cycle.
- `run` and `reverse` are sampled per cycle with no internal latching. A direction change takes effect on the next qualifying tick.
- Back-to-back ticks on consecutive cycles are legal; each one advances the counter.

## Timing
- Reset (rst=1 at an edge) sets, at that edge:
  - all `live_*` and `angle_*` to 0;
  - `angle_valid`, all `orbit_*` and `earth_years` to 0.
  - Reset mid-operation discards all state, including a `frame_start` or tick present in the same cycle.
- Tick in cycle N gives an updated live value after edge N. `orbit_x` is high for exactly cycle N+1, registered.
- `frame_start` in cycle N: `angle_*` are valid from cycle N+1, and `angle_valid` is high for cycle N+1 only.
- Latency from tick to visible output: up to one frame plus one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then forward: run=1, reverse=0, 5 Mercury ticks, then frame_start. Required: angle_mercur=5, angle_venus=0, angle_earth=0, angle_valid pulses 1 cycle after frame_start.
- Forward wrap: 360 Earth ticks, then frame_start. Required: orbit_earth pulses once (cycle after the 360th tick), angle_earth=0, earth_years=1.
- Reverse wrap: from reset, reverse=1, 1 Earth tick. Required: live value 359, orbit_earth pulse, earth_years stays 0 (saturation). Then reverse=0 and 1 tick: angle 0, orbit pulse, earth_years=1.
- Pause: run=0 during 10 ticks on all planets, then frame_start. Required: all angles unchanged. Ticks with run=1 afterwards resume from the held values.
- Simultaneous events: live Venus=41, tick_venus and frame_start in the same cycle. Required: angle_venus=41. The next frame_start gives 42.
- Reset mid-operation: angles non-zero and earth_years=3; assert rst for 1 cycle together with a tick and frame_start. Required: every output is 0 the cycle after, with no angle_valid or orbit pulse.
